upsample_2x_nn: RTL and testbench

UPSAMPLE_2X_NN -- requirements
Module: upsample_2x_nn

---
 rtl/upsample_2x_nn.sv | 177 +++++++++++++++++
 tb/tb_upsample_2x_nn.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_2x_nn.sv
// -----------------------------------------------------------------------------
// upsample_2x_nn
// 2x2 nearest-neighbour upsampler (inverse of the 2x2 pooling stage).
// Each input pixel is emitted twice horizontally. Each input row is emitted
// twice vertically: once live while it is loaded (LOAD), then again from a
// one-row line buffer (REPLAY). The output frame is 2*IN_WIDTH x 2*IN_HEIGHT.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active-high
//   in_valid       : input pixel valid
//   in_data        : input pixel, pooled-map raster order
//   in_ready       : combinational; block accepts in_data this cycle
//   out_valid      : output beat valid (registered)
//   out_data       : output pixel (registered)
//   out_ready      : downstream accepts beat
//   out_row_last   : last beat of each output row (registered)
//   out_frame_last : last beat of the last output row of a frame (registered)
// -----------------------------------------------------------------------------
module upsample_2x_nn #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IN_WIDTH   = 12,
    parameter int unsigned IN_HEIGHT  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_row_last,
    output logic                  out_frame_last
);

    // col counts 0..IN_WIDTH, rcol indexes 0..IN_WIDTH-1, row counts 0..IN_HEIGHT-1
    localparam int unsigned COL_W  = $clog2(IN_WIDTH + 1);
    localparam int unsigned RCOL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(IN_WIDTH);
    localparam logic [RCOL_W-1:0] RCOL_LAST = RCOL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_HEIGHT - 1);

    typedef enum logic {
        LOAD   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [COL_W-1:0]    col, col_nx;
    logic [RCOL_W-1:0]   rcol, rcol_nx, rcol_inc;
    logic                h, h_nx;
    logic [ROW_W-1:0]    row, row_nx;
    logic                out_valid_nx;
    logic [DATA_WIDTH-1:0] out_data_nx;
    logic                row_last_nx;
    logic                frame_last_nx;

    logic                fire;
    logic                accept;

    // One-row line buffer; contents are don't-care after reset
    logic [DATA_WIDTH-1:0] line_buf [IN_WIDTH];

    // Handshake decode. A new pixel may enter only when the current beat is
    // gone or is the second horizontal copy leaving this cycle, which gives
    // back-to-back output with no bubble between pixels of a LOAD row.
    always_comb begin
        in_ready = (state == LOAD) && (col < COL_FULL) &&
                   (!out_valid || (out_ready && h));
        fire     = out_valid && out_ready;
        accept   = in_valid && in_ready;
        rcol_inc = rcol + RCOL_W'(1);
    end

    // Line buffer write on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[col[RCOL_W-1:0]] <= in_data;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= LOAD;
            col            <= '0;
            rcol           <= '0;
            h              <= 1'b0;
            row            <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_row_last   <= 1'b0;
            out_frame_last <= 1'b0;
        end else begin
            state          <= state_nx;
            col            <= col_nx;
            rcol           <= rcol_nx;
            h              <= h_nx;
            row            <= row_nx;
            out_valid      <= out_valid_nx;
            out_data       <= out_data_nx;
            out_row_last   <= row_last_nx;
            out_frame_last <= frame_last_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        col_nx       = col;
        rcol_nx      = rcol;
        h_nx         = h;
        row_nx       = row;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;

        case (state)
            LOAD: begin
                if (accept) begin
                    // First horizontal copy of a fresh pixel
                    out_data_nx  = in_data;
                    out_valid_nx = 1'b1;
                    h_nx         = 1'b0;
                    col_nx       = col + COL_W'(1);
                end else if (fire) begin
                    if (!h) begin
                        h_nx = 1'b1;
                    end else if (col == COL_FULL) begin
                        // Live row done; start replaying it from the buffer
                        state_nx     = REPLAY;
                        rcol_nx      = '0;
                        h_nx         = 1'b0;
                        out_data_nx  = line_buf[0];
                        out_valid_nx = 1'b1;
                    end else begin
                        out_valid_nx = 1'b0;
                    end
                end
            end

            REPLAY: begin
                if (fire) begin
                    if (!h) begin
                        h_nx = 1'b1;
                    end else if (rcol == RCOL_LAST) begin
                        // Row pair complete; wait for the next input row
                        state_nx     = LOAD;
                        col_nx       = '0;
                        rcol_nx      = '0;
                        h_nx         = 1'b0;
                        out_valid_nx = 1'b0;
                        row_nx       = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                    end else begin
                        h_nx        = 1'b0;
                        rcol_nx     = rcol_inc;
                        out_data_nx = line_buf[rcol_inc];
                    end
                end
            end

            default: begin
                state_nx = LOAD;
            end
        endcase

        // Flags are derived from the next register values so they stay
        // aligned with the beat they describe and hold during a stall.
        row_last_nx   = out_valid_nx && h_nx &&
                        (((state_nx == LOAD)   && (col_nx  == COL_FULL)) ||
                         ((state_nx == REPLAY) && (rcol_nx == RCOL_LAST)));
        frame_last_nx = row_last_nx && (state_nx == REPLAY) && (row_nx == ROW_LAST);
    end

endmodule

// File: tb/tb_upsample_2x_nn.sv
// -----------------------------------------------------------------------------
// tb_upsample_2x_nn
// Bench for upsample_2x_nn with IN_WIDTH=4, IN_HEIGHT=2. A reference model
// pushes the expected output beats into a queue as each input is accepted;
// a negedge monitor pops and compares every fired beat and checks stall
// stability and in_ready during replay.
// -----------------------------------------------------------------------------
module tb_upsample_2x_nn;

    localparam int unsigned DW = 16;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          rl;
        logic          fl;
        logic          rep;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_row_last;
    logic          out_frame_last;

    upsample_2x_nn #(
        .DATA_WIDTH (DW),
        .IN_WIDTH   (W),
        .IN_HEIGHT  (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .out_row_last   (out_row_last),
        .out_frame_last (out_frame_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int cyc    = 0;
    int fire_cyc [8];
    bit abort      = 1'b0;
    bit rand_ready = 1'b0;

    exp_t exp_q [$];

    // Reference model state
    logic [DW-1:0] m_line [W];
    int m_col = 0;
    int m_row = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        exp_q.delete();
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        m_line[m_col] = d;
        e = '{d: d, rl: 1'b0, fl: 1'b0, rep: 1'b0};
        exp_q.push_back(e);
        e.rl = (m_col == W - 1);
        exp_q.push_back(e);
        m_col++;
        if (m_col == W) begin
            for (int i = 0; i < W; i++) begin
                for (int k = 0; k < 2; k++) begin
                    e.d   = m_line[i];
                    e.rl  = (i == W - 1) && (k == 1);
                    e.fl  = e.rl && (m_row == H - 1);
                    e.rep = 1'b1;
                    exp_q.push_back(e);
                end
            end
            m_col = 0;
            m_row = (m_row + 1) % H;
        end
    endtask

    // Output monitor: scoreboard compare, stall stability, replay in_ready
    logic          stall_prev = 1'b0;
    logic [DW-1:0] p_data;
    logic          p_rl, p_fl;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if ({out_valid, out_data, out_row_last, out_frame_last} !==
                    {1'b1, p_data, p_rl, p_fl}) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0d rl=%0b fl=%0b want v=1 d=%0d rl=%0b fl=%0b",
                             out_valid, out_data, out_row_last, out_frame_last, p_data, p_rl, p_fl);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%0d with empty scoreboard", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_row_last, out_frame_last} !== {e.d, e.rl, e.fl}) begin
                        errors++;
                        $display("FAIL beat_%0d: got d=%0d rl=%0b fl=%0b want d=%0d rl=%0b fl=%0b",
                                 beats, out_data, out_row_last, out_frame_last, e.d, e.rl, e.fl);
                    end
                    if (e.rep) begin
                        checks++;
                        if (in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL replay_in_ready: got %0b want 0", in_ready);
                        end
                    end
                end
                if (beats < 8) fire_cyc[beats] = cyc;
                beats++;
            end
            stall_prev = out_valid && !out_ready;
            p_data = out_data;
            p_rl   = out_row_last;
            p_fl   = out_frame_last;
        end
    end

    // Random backpressure source
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one pixel and hold it until accepted (bounded)
    task automatic send(input logic [DW-1:0] d);
        int  n;
        bit  done;
        if (abort) return;
        in_data  = d;
        in_valid = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", d, n);
                abort = 1'b1;
                done  = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait until all expected beats have been seen (bounded)
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, out_row_last, out_frame_last, out_data} !== {3'b000, DW'(0)}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b rl=%0b fl=%0b d=%0d want all 0",
                     out_valid, out_row_last, out_frame_last, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Two rows 1..4 and 5..8 back to back with out_ready high
    task automatic test_basic();
        out_ready = 1'b1;
        beats = 0;
        for (int i = 1; i <= 8; i++) send(DW'(i));
        wait_drain("basic");
        checks++;
        if (beats !== 32) begin
            errors++;
            $display("FAIL basic_beat_count: got %0d want 32", beats);
        end
        checks++;
        if (fire_cyc[7] - fire_cyc[0] !== 7) begin
            errors++;
            $display("FAIL zero_bubble: got span %0d cycles want 7", fire_cyc[7] - fire_cyc[0]);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    // out_ready held low 3 cycles mid-row
    task automatic test_stall();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(DW'(20 + i));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_ready_%0d: got in_ready=%0b out_valid=%0b want 0 1",
                                 k, in_ready, out_valid);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("stall");
    endtask

    // Random input gaps and random backpressure over many frames
    task automatic test_random();
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < W * H; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send(DW'($urandom));
            end
        end
        wait_drain("random");
        rand_ready = 1'b0;
        out_ready  = 1'b1;
    endtask

    // Reset during replay of row 0, then a fresh frame starting with 9
    task automatic test_reset_replay();
        int n = 0;
        out_ready = 1'b1;
        beats = 0;
        for (int i = 1; i <= 4; i++) send(DW'(i));
        while (beats < 9 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (beats < 9) begin
            errors++;
            $display("FAIL reach_replay: got %0d beats want >=9", beats);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_replay: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        beats = 0;
        for (int i = 9; i <= 16; i++) send(DW'(i));
        wait_drain("post_reset");
        checks++;
        if (beats !== 32) begin
            errors++;
            $display("FAIL post_reset_beats: got %0d want 32", beats);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_reset_replay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
